// File: rtl/lbp_encode_arbiter.sv
// Round-robin front end for a shared leading-bit-position encoder: one operand
// per cycle is granted, encoded and held in a single result register tagged with its requester.
module lbp_encode_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [3:0]           res_code,
    output logic [ID_W-1:0]      res_id,
    input  logic                 clr_cnt,
    output logic [7:0]           zero_cnt
);

    // Handshake rule for both ports: a transfer happens on a rising edge where
    // valid and ready are both high; ready here never looks at the payload.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] ptr;
    logic            can_accept;
    logic            accept;
    logic [ID_W-1:0] grant_id;
    logic [7:0]      sel_data;
    logic [3:0]      sel_code;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Ascending scan so the highest set bit overwrites all lower ones.
    function automatic logic [3:0] lbp_code(input logic [7:0] d);
        logic [3:0] code;
        code = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            if (d[k]) code = 4'(2 * k);
        end
        return code;
    endfunction

    assign res_valid  = (state == FULL);
    assign can_accept = (state == EMPTY) || res_ready;

    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        accept    = 1'b0;
        if (can_accept) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                if (!accept && req_valid[wrap_add(ptr, off)]) begin
                    accept                      = 1'b1;
                    grant_id                    = wrap_add(ptr, off);
                    req_ready[wrap_add(ptr, off)] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) sel_data = req_data[8*i +: 8];
        end
    end

    assign sel_code = lbp_code(sel_data);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (res_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= '0;
            res_code <= 4'b0000;
            res_id   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr      <= wrap_add(grant_id, 1);
                res_code <= sel_code;
                res_id   <= grant_id;
            end
        end
    end

    // Clear wins over a simultaneous zero-operand accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_cnt <= 8'd0;
        end else if (clr_cnt) begin
            zero_cnt <= 8'd0;
        end else if (accept && (sel_data == 8'd0) && (zero_cnt != 8'hFF)) begin
            zero_cnt <= zero_cnt + 8'd1;
        end
    end

endmodule

// File: doc/lbp_encode_arbiter.md
# lbp_encode_arbiter

Shared-resource front end for the leading-bit-position (LBP) encoder in the ODPC path. It arbitrates round-robin among NUM_REQ processing-lane requesters, passes the granted 8-bit operand through a single encoder instance and returns a registered 4-bit code tagged with the requester index. A saturating counter tracks all-zero operands for the fault-monitoring logic.

## Interface

- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of res_id; must satisfy 2^ID_W >= NUM_REQ
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  bit i: requester i has an operand
- req_data  in  8*NUM_REQ  operand of requester i at [8*i+7 : 8*i]
- req_ready  out  NUM_REQ  one-hot grant; operand i is accepted when req_valid[i] && req_ready[i]
- res_valid  out  1  result register holds a valid result
- res_ready  in  1  downstream accepts the result this cycle
- res_code  out  4  LBP code
- res_id  out  ID_W  index of the requester that produced res_code
- clr_cnt  in  1  synchronous clear of zero_cnt
- zero_cnt  out  8  saturating count of accepted all-zero operands

## Operation

- Encoding: for operand d[7:0], scan from d[7] down to d[0]; first set bit d[k] gives res_code = 2*k (d[7]→4'b1110, d[6]→4'b1100 … d[0]→4'b0000). d = 0 gives 4'b0001. Only the highest set bit matters.
- can_accept = !res_valid || res_ready.
- Arbitration: when can_accept, req_ready is one-hot on the first asserted req_valid found scanning from index ptr upward, wrapping modulo NUM_REQ. When !can_accept or no req_valid asserted, req_ready = 0.
- req_ready is combinational from req_valid, ptr, res_valid and res_ready; it must not depend on req_data.
- On accept of requester g: ptr ← (g+1) mod NUM_REQ; ptr is unchanged on cycles without an accept.
- Output register states: EMPTY (res_valid=0) and FULL (res_valid=1).
  - EMPTY + accept → FULL, load code/id.
  - FULL + res_ready + accept → FULL, load new code/id (back-to-back).
  - FULL + res_ready + no accept → EMPTY; res_code and res_id keep their last values.
  - FULL + !res_ready → hold res_code, res_id and res_valid stable.
- zero_cnt: increments on every accept whose operand is 0; saturates at 255. clr_cnt = 1 forces 0 on the next edge, and takes priority over a simultaneous zero accept.
- Requesters may change req_data or deassert req_valid at any time before they are granted. The block captures only the granted operand and only on the accept edge.

## Timing

- Reset values: res_valid=0, res_code=4'b0000, res_id=0, zero_cnt=0, ptr=0. req_ready follows req_valid combinationally after reset, so requester 0 has first priority.
- Latency: the result is visible on res_valid/res_code/res_id on the cycle after the accept edge.
- Throughput: one operand per cycle while res_ready stays high.
- Under sustained contention, each valid requester is granted at least once every NUM_REQ accepts.
- Reset asserted mid-operation clears the pending result immediately and asynchronously. Operands in flight are dropped, not replayed.
- No combinational path from res_ready to res_valid, res_code or res_id.

## Test plan

- Encode sweep: single requester 0, res_ready=1, operands 0x80, 0x40, 0x01, 0xFF, 0x00, 0x13 → codes 14, 12, 0, 14, 1, 8 on consecutive cycles, res_id=0, zero_cnt=1.
- Round-robin: all 4 req_valid held high, res_ready=1 → grant order 0,1,2,3,0,1… one per cycle; res_id trails req_ready by one cycle.
- Back-pressure: result FULL and res_ready=0 for 5 cycles with requests pending → req_ready=0 and res_code/res_id/res_valid stable. When res_ready rises, the next grant goes to ptr's requester in that same cycle.
- Pointer skip: ptr=1, only req_valid[3] and req_valid[0] set → grant 3, then 0; ptr ends at 1.
- Counter: 260 accepted zero operands → zero_cnt=255. clr_cnt pulsed together with a zero-operand accept → zero_cnt=0.
- Async reset: assert rst between edges while res_valid=1 → res_valid=0, zero_cnt=0 before the next edge. After release, requester 0 is granted first.
